rank_classifier: RTL and testbench
==================================

Name: rank_classifier

Overview:
- Downstream consumer of the per-rank XOR template-match stages, one per rank kernel A..K. Each stage produces a mismatch score; a lower score is a better match.
- Latches one frame's worth of scores and scans them sequentially for the minimum.
- Rejects weak matches against a threshold.
- Debounces the winning rank across frames, so the display/game logic receives a stable card rank.

Parameters:
- NUM_RANKS, 13, number of score lanes; lane i is rank code i+1 (0=Ace ... 12=King).
- SCORE_W, 11, score width; equals $clog2(28*40).
- REJECT_THRESH, 400, best score strictly greater than this is rejected (rank 0).
- CONFIRM_FRAMES, 3, consecutive identical results needed to update the stable output; minimum 1.
- MIN_MARGIN, 40, minimum second-best minus best gap; used only with RANK_MARGIN_EN.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- scores_in  in  NUM_RANKS*SCORE_W  packed scores; lane i at bits [i*SCORE_W +: SCORE_W].
- scores_valid  in  1  single-cycle pulse; scores_in is valid this cycle.
- busy  out  1  high while a scan is in progress.
- dropped  out  1  one-cycle pulse when scores_valid arrives while busy.
- rank_out  out  4  per-frame result; 0 = rejected, 1..NUM_RANKS = rank code.
- best_score  out  SCORE_W  minimum score of the last frame.
- result_valid  out  1  one-cycle pulse; rank_out/best_score updated.
- stable_rank  out  4  debounced rank; 0 = no card.
- stable_valid  out  1  level; high while stable_rank is a confirmed nonzero rank.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0.
  - Score bank, index, candidate and count go to 0.
  - A scan in progress is abandoned and produces no result_valid.
- States: IDLE, SCAN, DECIDE.
- IDLE:
  - On scores_valid, register all lanes into the internal bank, set idx=0, best=all-ones, best_idx=0, and go to SCAN.
  - busy=0 in IDLE.
- SCAN, one lane per cycle:
  - If bank[idx] < best (strictly less), set best=bank[idx] and best_idx=idx.
  - Ties keep the lower index.
  - After idx=NUM_RANKS-1 is compared, go to DECIDE.
  - idx does not wrap.
- DECIDE, one cycle:
  - rank_out = (best > REJECT_THRESH) ? 0 : best_idx+1.
  - best_score = best.
  - result_valid=1 for exactly one cycle.
  - Update the debounce, then return to IDLE.
- Latency: scores_valid sampled at edge E0 → result_valid high in the cycle after edge E0+NUM_RANKS+2.
  - With defaults, 15 edges.
  - busy is high from E0+1 until the result edge.
- Back-to-back frames:
  - scores_valid is accepted in the same cycle result_valid is high, because the FSM is already IDLE.
  - scores_valid while busy is ignored; the bank is unchanged and dropped pulses for 1 cycle.
- Debounce, evaluated on each result:
  - If rank_out == candidate, count = min(count+1, CONFIRM_FRAMES).
  - Otherwise candidate=rank_out and count=1.
  - When count == CONFIRM_FRAMES:
    - stable_rank=candidate.
    - stable_valid = (candidate != 0).
  - Otherwise stable_rank and stable_valid hold.
  - A confirmed rejection (card removed) therefore clears the stable output to 0/0.
- Arithmetic:
  - All compares are unsigned over SCORE_W bits.
  - rank_out is zero-extended from $clog2(NUM_RANKS) bits to 4 bits.

Optional Feature:
- Macro: RANK_MARGIN_EN.
- When defined:
  - SCAN also tracks second-best, initialised to all-ones.
  - On a new best, the old best becomes second.
  - Otherwise, if bank[idx] < second, second=bank[idx].
  - A lane equal to best updates second, so a tie gives a margin of 0.
  - DECIDE additionally rejects (rank_out=0) when second-best minus best < MIN_MARGIN.
  - The subtraction is unsigned SCORE_W; second >= best is guaranteed.
- When not defined:
  - No second-best register exists.
  - Only REJECT_THRESH applies.
  - MIN_MARGIN is unused.
- Latency is identical in both builds.

Test Plan:
- Reset mid-SCAN: assert rst 5 cycles after scores_valid → busy=0 immediately; no result_valid for that frame; all outputs 0.
- Single frame with lane 2 = 100 and others = 900 → result_valid at edge 15; rank_out=3; best_score=100; stable_valid stays 0.
- Tie, lanes 4 and 9 = 150 and others = 800 → rank_out=5, lower index wins. With RANK_MARGIN_EN and MIN_MARGIN=40 → rank_out=0.
- Reject, all lanes ≥ 401 with min 401 on lane 0 → rank_out=0 and best_score=401. Same frame with lane 0 = 400 → rank_out=1, since the threshold is inclusive.
- Debounce, results 7,7,7 then 0,0,0:
  - Before the 3rd result: stable_rank=0, stable_valid=0.
  - After the 3rd result: stable_rank=7, stable_valid=1.
  - Sequence 7,7,5,7 gives no stable change.
  - The trailing 0,0,0 clears stable to 0/0 on its 3rd result.
- Overrun: scores_valid again at E0+3 → dropped pulses at E0+4; result reflects the first frame only. A scores_valid coincident with result_valid is accepted; its result appears 15 edges later.

Source files
------------

// File: rtl/rank_classifier_if.sv
// Score-frame / result bus between the template-match stages and rank_classifier.
// The master drives frames in and collects results; the slave is the classifier.
interface rank_classifier_if #(
  parameter int NUM_RANKS = 13,
  parameter int SCORE_W   = 11
);
   logic [NUM_RANKS*SCORE_W-1:0] scores_in;
   logic                         scores_valid;
   logic                         busy;
   logic                         dropped;
   logic [3:0]                   rank_out;
   logic [SCORE_W-1:0]           best_score;
   logic                         result_valid;
   logic [3:0]                   stable_rank;
   logic                         stable_valid;

   // scores_valid is a one-cycle pulse with no ready: it is taken only while
   // busy is low, otherwise it is discarded and dropped pulses one cycle later.
   modport master (
      output scores_in, scores_valid,
      input  busy, dropped, rank_out, best_score, result_valid,
             stable_rank, stable_valid
   );

   modport slave (
      input  scores_in, scores_valid,
      output busy, dropped, rank_out, best_score, result_valid,
             stable_rank, stable_valid
   );
endinterface

// File: rtl/rank_classifier.sv
// Latches a frame of per-rank mismatch scores, scans for the minimum, rejects weak
// matches and debounces the winner. Optional RANK_MARGIN_EN adds a best/second margin test.
module rank_classifier #(
   parameter int NUM_RANKS      = 13,
   parameter int SCORE_W        = 11,
   parameter int REJECT_THRESH  = 400,
`ifdef RANK_MARGIN_EN
   parameter int MIN_MARGIN     = 40,
`endif
   parameter int CONFIRM_FRAMES = 3
) (
   input  logic              clk,
   input  logic              rst,
   rank_classifier_if.slave  bus,
   output logic [1:0]        o_dbg_state
);
   localparam int IDX_W = $clog2(NUM_RANKS);
   localparam int CNT_W = $clog2(CONFIRM_FRAMES + 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DECIDE = 2'd2} state_t;

   state_t             r_state, w_next;
   logic [SCORE_W-1:0] r_bank [NUM_RANKS];
   logic [IDX_W-1:0]   r_idx, r_best_idx;
   logic [SCORE_W-1:0] r_best, r_lane;
   logic               r_primed;
   logic [3:0]         r_cand;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_dropped, r_result_valid, r_stable_valid;
   logic [3:0]         r_rank, r_stable_rank;
   logic [SCORE_W-1:0] r_best_score;
`ifdef RANK_MARGIN_EN
   logic [SCORE_W-1:0] r_second;
`endif

   logic               w_last, w_reject, w_match;
   logic [IDX_W-1:0]   w_idx_inc;
   logic [3:0]         w_rank;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // r_lane holds the lane fetched last cycle, so the first SCAN cycle only primes it.
   assign w_last    = r_primed && (r_idx == IDX_W'(NUM_RANKS - 1));
   assign w_idx_inc = r_idx + 1'b1;

`ifdef RANK_MARGIN_EN
   assign w_reject = (r_best > SCORE_W'(REJECT_THRESH)) ||
                     ((r_second - r_best) < SCORE_W'(MIN_MARGIN));
`else
   assign w_reject = (r_best > SCORE_W'(REJECT_THRESH));
`endif
   assign w_rank    = w_reject ? 4'd0 : (4'(r_best_idx) + 4'd1);
   assign w_match   = (w_rank == r_cand);
   assign w_cnt_nxt = !w_match ? CNT_W'(1) :
                      (r_cnt == CNT_W'(CONFIRM_FRAMES)) ? r_cnt : (r_cnt + 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (bus.scores_valid) w_next = ST_SCAN;
         ST_SCAN:   if (w_last) w_next = ST_DECIDE;
         ST_DECIDE: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_RANKS; i++) r_bank[i] <= '0;
         r_idx          <= '0;
         r_best_idx     <= '0;
         r_best         <= '0;
         r_lane         <= '0;
         r_primed       <= 1'b0;
         r_cand         <= '0;
         r_cnt          <= '0;
         r_dropped      <= 1'b0;
         r_result_valid <= 1'b0;
         r_rank         <= '0;
         r_best_score   <= '0;
         r_stable_rank  <= '0;
         r_stable_valid <= 1'b0;
`ifdef RANK_MARGIN_EN
         r_second       <= '0;
`endif
      end else begin
         r_dropped      <= bus.scores_valid && (r_state != ST_IDLE);
         r_result_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.scores_valid) begin
                  for (int i = 0; i < NUM_RANKS; i++)
                     r_bank[i] <= bus.scores_in[i*SCORE_W +: SCORE_W];
                  r_idx      <= '0;
                  r_best     <= '1;
                  r_best_idx <= '0;
                  r_primed   <= 1'b0;
`ifdef RANK_MARGIN_EN
                  r_second   <= '1;
`endif
               end
            end
            ST_SCAN: begin
               if (!r_primed) begin
                  r_lane   <= r_bank[0];
                  r_primed <= 1'b1;
               end else begin
                  // Strict less-than: on a tie the lower index already holds best.
                  if (r_lane < r_best) begin
                     r_best     <= r_lane;
                     r_best_idx <= r_idx;
`ifdef RANK_MARGIN_EN
                     r_second   <= r_best;
                  end else if (r_lane < r_second) begin
                     r_second   <= r_lane;
`endif
                  end
                  if (!w_last) begin
                     r_idx  <= w_idx_inc;
                     r_lane <= r_bank[w_idx_inc];
                  end
               end
            end
            ST_DECIDE: begin
               r_rank         <= w_rank;
               r_best_score   <= r_best;
               r_result_valid <= 1'b1;
               r_cand         <= w_rank;
               r_cnt          <= w_cnt_nxt;
               if (w_cnt_nxt == CNT_W'(CONFIRM_FRAMES)) begin
                  r_stable_rank  <= w_rank;
                  r_stable_valid <= (w_rank != 4'd0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.dropped      = r_dropped;
   assign bus.rank_out     = r_rank;
   assign bus.best_score   = r_best_score;
   assign bus.result_valid = r_result_valid;
   assign bus.stable_rank  = r_stable_rank;
   assign bus.stable_valid = r_stable_valid;
   assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_rank_classifier.sv
// Directed bench for rank_classifier: reset, latency, ties, threshold, debounce, overrun.
// Expected values are hand-computed per frame; RANK_MARGIN_EN only changes the tie case.
module tb_rank_classifier;
   localparam int NR = 13;
   localparam int SW = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         rv_seen = 0;
   int         lat;

   always #5 clk = ~clk;

   rank_classifier_if #(.NUM_RANKS(NR), .SCORE_W(SW)) bus ();

   rank_classifier #(
      .NUM_RANKS(NR), .SCORE_W(SW), .REJECT_THRESH(400), .CONFIRM_FRAMES(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   always @(negedge clk) if (bus.result_valid) rv_seen++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [NR*SW-1:0] mk_frame(input int fill, input int la, input int va,
                                                 input int lb, input int vb);
      logic [NR*SW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*SW +: SW] = SW'(fill);
      if (la >= 0) f[la*SW +: SW] = SW'(va);
      if (lb >= 0) f[lb*SW +: SW] = SW'(vb);
      return f;
   endfunction

   // Called at a negedge: pulse scores_valid across exactly one rising edge.
   task automatic drive_frame(input logic [NR*SW-1:0] f);
      bus.scores_in    = f;
      bus.scores_valid = 1'b1;
      @(negedge clk);
      bus.scores_valid = 1'b0;
   endtask

   // Counts rising edges until result_valid is seen; returns at that negedge.
   task automatic wait_result(output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.result_valid) got = 1'b1;
      end
      check_eq("result_arrived", 32'(got), 32'd1);
   endtask

   task automatic run_frame(input string tag, input logic [NR*SW-1:0] f,
                            input int exp_rank, input int exp_best);
      drive_frame(f);
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_result(lat);
      check_eq({tag, "_latency"}, 32'(lat), 32'd15);
      check_eq({tag, "_rank"}, 32'(bus.rank_out), 32'(exp_rank));
      check_eq({tag, "_best"}, 32'(bus.best_score), 32'(exp_best));
      check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_stable(input string tag, input int exp_rank, input int exp_valid);
      check_eq({tag, "_stable_rank"}, 32'(bus.stable_rank), 32'(exp_rank));
      check_eq({tag, "_stable_valid"}, 32'(bus.stable_valid), 32'(exp_valid));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, "_dropped"}, 32'(bus.dropped), 32'd0);
      check_eq({tag, "_rank"}, 32'(bus.rank_out), 32'd0);
      check_eq({tag, "_best"}, 32'(bus.best_score), 32'd0);
      check_eq({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
      check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
      check_stable(tag, 0, 0);
   endtask

   initial begin
      int exp_tie;
      rst              = 1'b1;
      bus.scores_in    = '0;
      bus.scores_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a scan abandons the frame.
      drive_frame(mk_frame(900, 2, 100, -1, 0));
      repeat (4) @(negedge clk);
      check_eq("midscan_busy_before", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("midscan_reset");
      @(negedge clk);
      rst     = 1'b0;
      rv_seen = 0;
      repeat (20) @(negedge clk);
      check_eq("midscan_no_result", 32'(rv_seen), 32'd0);

      run_frame("single", mk_frame(900, 2, 100, -1, 0), 3, 100);
      check_stable("single", 0, 0);
      @(negedge clk);
      check_eq("single_rv_one_cycle", 32'(bus.result_valid), 32'd0);

`ifdef RANK_MARGIN_EN
      exp_tie = 0;
`else
      exp_tie = 5;
`endif
      run_frame("tie", mk_frame(800, 4, 150, 9, 150), exp_tie, 150);
      run_frame("reject", mk_frame(900, 0, 401, -1, 0), 0, 401);
      run_frame("thresh_incl", mk_frame(900, 0, 400, -1, 0), 1, 400);

      // Debounce: 7,7,7 confirms; 7,7,5,7 holds; 0,0,0 clears.
      run_frame("deb7a", mk_frame(900, 6, 50, -1, 0), 7, 50);
      check_stable("deb7a", 0, 0);
      run_frame("deb7b", mk_frame(900, 6, 50, -1, 0), 7, 50);
      check_stable("deb7b", 0, 0);
      run_frame("deb7c", mk_frame(900, 6, 50, -1, 0), 7, 50);
      check_stable("deb7c", 7, 1);
      run_frame("hold7a", mk_frame(900, 6, 50, -1, 0), 7, 50);
      check_stable("hold7a", 7, 1);
      run_frame("hold5", mk_frame(900, 4, 60, -1, 0), 5, 60);
      check_stable("hold5", 7, 1);
      run_frame("hold7b", mk_frame(900, 6, 50, -1, 0), 7, 50);
      check_stable("hold7b", 7, 1);
      run_frame("clr0a", mk_frame(900, -1, 0, -1, 0), 0, 900);
      check_stable("clr0a", 7, 1);
      run_frame("clr0b", mk_frame(900, -1, 0, -1, 0), 0, 900);
      check_stable("clr0b", 7, 1);
      run_frame("clr0c", mk_frame(900, -1, 0, -1, 0), 0, 900);
      check_stable("clr0c", 0, 0);

      // Overrun: second frame at E0+3 is dropped; result is from the first frame.
      drive_frame(mk_frame(900, 10, 20, -1, 0));
      repeat (2) @(negedge clk);
      drive_frame(mk_frame(900, 1, 10, -1, 0));
      check_eq("overrun_dropped", 32'(bus.dropped), 32'd1);
      @(negedge clk);
      check_eq("overrun_dropped_pulse", 32'(bus.dropped), 32'd0);
      wait_result(lat);
      check_eq("overrun_latency", 32'(lat), 32'd11);
      check_eq("overrun_rank", 32'(bus.rank_out), 32'd11);
      check_eq("overrun_best", 32'(bus.best_score), 32'd20);

      // Frame presented in the result_valid cycle is accepted.
      drive_frame(mk_frame(900, 12, 30, -1, 0));
      check_eq("b2b_not_dropped", 32'(bus.dropped), 32'd0);
      check_eq("b2b_busy", 32'(bus.busy), 32'd1);
      wait_result(lat);
      check_eq("b2b_latency", 32'(lat), 32'd15);
      check_eq("b2b_rank", 32'(bus.rank_out), 32'd13);
      check_eq("b2b_best", 32'(bus.best_score), 32'd30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
